// File: rtl/soc_uart_pkg.sv
// Shared UART definitions: serializer states, LSR bit positions and default bus addresses.
package soc_uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_e;

   localparam int unsigned LSR_THRE = 5;
   localparam int unsigned LSR_TEMT = 6;

   localparam logic [31:0] UART_TX_ADDR_DFLT  = 32'h1000_0000;
   localparam logic [31:0] UART_LSR_ADDR_DFLT = 32'h1000_0005;

   localparam logic [15:0] MIN_BIT_PERIOD = 16'd2;

   function automatic logic [15:0] bit_period(input logic [15:0] d);
      return (d < MIN_BIT_PERIOD) ? MIN_BIT_PERIOD : d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; full/empty derive from the registered occupancy count only.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE  = 1;
   localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];
   localparam logic [AW-1:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PTR_ONE;
         if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: bus decode, TX FIFO and 8N1 serializer with back-to-back frames.
module uart_tx_fifo
   import soc_uart_pkg::*;
#(
   parameter logic [31:0] TX_ADDR  = UART_TX_ADDR_DFLT,
   parameter logic [31:0] LSR_ADDR = UART_LSR_ADDR_DFLT,
   parameter int unsigned DEPTH    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   input  logic [15:0] div,
   output logic        tx_out,
   output logic        irq_thre
);

   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        hit_tx, hit_lsr, push;
   logic [7:0]  lsr;

   logic        fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_dout;
   logic [$clog2(DEPTH):0] fifo_count;

   tx_state_e   state_q;
   logic        tx_q;
   logic [7:0]  shift_q;
   logic [2:0]  idx_q;
   logic [15:0] cnt_q, period_q;
   logic        bit_done;

   logic        unused_wdata;
   assign unused_wdata = ^wdata[31:8];

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .din  (wdata[7:0]),
      .pop  (fifo_pop),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );

   assign hit_tx  = valid && !ready_q && (addr == TX_ADDR)  && (wstrb != '0);
   assign hit_lsr = valid && !ready_q && (addr == LSR_ADDR) && (wstrb == '0);
   assign push    = hit_tx && !fifo_full;

   always_comb begin
      lsr           = '0;
      lsr[LSR_THRE] = fifo_empty;
      lsr[LSR_TEMT] = fifo_empty && (state_q == S_IDLE);
      ready_d       = push || hit_lsr;
      rdata_d       = hit_lsr ? {16'b0, lsr, 8'b0} : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end
   end

   assign bit_done = (cnt_q == period_q - 16'd1);
   // The pop coincides with the IDLE/STOP -> START transition so frames chain without a gap.
   assign fifo_pop = !fifo_empty &&
                     ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tx_q     <= 1'b1;
         shift_q  <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         period_q <= MIN_BIT_PERIOD;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (fifo_pop) begin
                  state_q  <= S_START;
                  tx_q     <= 1'b0;
                  shift_q  <= fifo_dout;
                  period_q <= bit_period(div);
                  cnt_q    <= '0;
               end
            end
            S_START: begin
               if (bit_done) begin
                  state_q <= S_DATA;
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  tx_q    <= shift_q[0];
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  cnt_q <= '0;
                  if (idx_q == 3'd7) begin
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                     tx_q  <= shift_q[idx_q + 3'd1];
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_STOP: begin
               if (bit_done) begin
                  cnt_q <= '0;
                  if (fifo_pop) begin
                     state_q  <= S_START;
                     tx_q     <= 1'b0;
                     shift_q  <= fifo_dout;
                     period_q <= bit_period(div);
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign ready    = ready_q;
   assign rdata    = rdata_q;
   assign tx_out   = tx_q;
   assign irq_thre = (fifo_count == '0);

endmodule
